fp64_div_seq: RTL

Sequential IEEE 754 double-precision divider computing result = a / b, the inverse of the team's fused multiply path. It uses a multi-cycle radix-2 restoring iteration instead of a wide array. It sits beside the FP64 multiply/FMA/FMS units in the arithmetic cluster. Operands are accepted through a valid/ready handshake, and the result is held until the consumer takes it.

---
 rtl/fp64_pkg.sv | 30 +++
 rtl/fp64_div_round_pack.sv | 66 ++++++
 rtl/fp64_div_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fp64_pkg.sv
// Shared FP64 definitions for the arithmetic cluster: format widths, special constants,
// divider FSM states and a leading-zero helper used when FP64_DIV_SEQ_DENORM_EN is defined.
package fp64_pkg;

  localparam int FP64_EXP_W  = 11;
  localparam int FP64_MANT_W = 52;
  localparam int FP64_BIAS   = 1023;

  localparam logic [63:0] FP64_QNAN    = 64'h7FF8000000000001;
  localparam logic [63:0] FP64_POS_INF = 64'h7FF0000000000000;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    ROUND,
    DONE
  } fp64_div_state_t;

  // Scans from the LSB up so the highest set bit wins; an all-zero field reports 52.
  function automatic logic [5:0] lzc52(input logic [51:0] f);
    logic [5:0] n;
    n = 6'd52;
    for (int i = 0; i < 52; i++) begin
      if (f[i]) n = 6'(51 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp64_div_round_pack.sv
// Round-to-nearest-even and packing of the divider quotient, with overflow to infinity.
// FP64_DIV_SEQ_DENORM_EN selects gradual underflow; otherwise tiny results flush to zero.
module fp64_div_round_pack
  import fp64_pkg::*;
(
  input  logic               sign,
  input  logic signed [12:0] exp_q,
  input  logic [53:0]        quot,
  input  logic               sticky_in,
  output logic [63:0]        res
);

  logic [53:0]        sig;
  logic               lost;
  logic [FP64_MANT_W:0] mant;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [53:0]        rounded;
  logic signed [12:0] exp_adj;
  logic               tiny;
`ifdef FP64_DIV_SEQ_DENORM_EN
  logic [6:0]         shamt;
  logic [107:0]       wide;
`else
  logic               unused_rounded_msb;
  assign unused_rounded_msb = rounded[52];
`endif

  // quot holds 53 significand bits plus guard; the remainder test arrives as sticky_in.
  always_comb begin
    sig  = quot;
    lost = 1'b0;
    tiny = (exp_q <= 13'sd0);
`ifdef FP64_DIV_SEQ_DENORM_EN
    shamt = 7'd0;
    wide  = '0;
    if (tiny) begin
      shamt = (exp_q < -13'sd54) ? 7'd55 : 7'(13'sd1 - exp_q);
      wide  = {quot, 54'b0} >> shamt;
      sig   = wide[107:54];
      lost  = |wide[53:0];
    end
`endif
    mant     = sig[53:1];
    guard    = sig[0];
    sticky   = sticky_in | lost;
    round_up = guard & (sticky | mant[0]);
    rounded  = {1'b0, mant} + {53'b0, round_up};
    exp_adj  = exp_q + (rounded[53] ? 13'sd1 : 13'sd0);

    if (exp_adj >= 13'sd2047) begin
      res = {sign, FP64_POS_INF[62:0]};
    end else if (tiny) begin
`ifdef FP64_DIV_SEQ_DENORM_EN
      // A subnormal that rounds up into bit 52 becomes the smallest normal.
      res = {sign, {(FP64_EXP_W-1){1'b0}}, rounded[52], rounded[51:0]};
`else
      res = {sign, 63'b0};
`endif
    end else begin
      res = {sign, exp_adj[FP64_EXP_W-1:0], rounded[51:0]};
    end
  end

endmodule

// File: rtl/fp64_div_seq.sv
// Sequential FP64 divider, radix-2 restoring, one quotient bit per cycle with valid/ready ports.
// Define FP64_DIV_SEQ_DENORM_EN for subnormal inputs/outputs; otherwise they flush to zero.
module fp64_div_seq
  import fp64_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        div_by_zero
);

  fp64_div_state_t    state;
  logic [63:0]        a_r, b_r;
  logic [53:0]        rem;
  logic [52:0]        mant_b;
  logic [53:0]        quot;
  logic [5:0]         cnt;
  logic signed [12:0] exp_q;
  logic               sign_q;

  logic [10:0]        ea_raw, eb_raw;
  logic [51:0]        fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [52:0]        ma, mb;
  logic signed [12:0] ea, eb;
  logic               sgn;
  logic               is_special, special_dbz;
  logic [63:0]        special_res;
  logic               rem_ge;
  logic [53:0]        rem_sub, rem_next;
  logic [63:0]        rp_result;
`ifdef FP64_DIV_SEQ_DENORM_EN
  logic [5:0]         sh_a, sh_b;
`endif

  // Operand classification and normalisation, evaluated while in PREP.
  always_comb begin
    ea_raw = a_r[62:52];
    eb_raw = b_r[62:52];
    fa     = a_r[51:0];
    fb     = b_r[51:0];
    sgn    = a_r[63] ^ b_r[63];
    a_nan  = (ea_raw == '1) && (fa != '0);
    b_nan  = (eb_raw == '1) && (fb != '0);
    a_inf  = (ea_raw == '1) && (fa == '0);
    b_inf  = (eb_raw == '1) && (fb == '0);
    ma     = {1'b1, fa};
    mb     = {1'b1, fb};
    ea     = $signed({2'b0, ea_raw});
    eb     = $signed({2'b0, eb_raw});
`ifdef FP64_DIV_SEQ_DENORM_EN
    a_zero = (ea_raw == '0) && (fa == '0);
    b_zero = (eb_raw == '0) && (fb == '0);
    sh_a   = lzc52(fa) + 6'd1;
    sh_b   = lzc52(fb) + 6'd1;
    if (ea_raw == '0) begin
      ma = {1'b0, fa} << sh_a;
      ea = 13'sd1 - $signed({7'b0, sh_a});
    end
    if (eb_raw == '0) begin
      mb = {1'b0, fb} << sh_b;
      eb = 13'sd1 - $signed({7'b0, sh_b});
    end
`else
    a_zero = (ea_raw == '0);
    b_zero = (eb_raw == '0);
`endif

    is_special  = 1'b1;
    special_dbz = 1'b0;
    special_res = FP64_QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res = FP64_QNAN;
    end else if (a_inf) begin
      special_res = {sgn, FP64_POS_INF[62:0]};
    end else if (b_zero) begin
      special_res = {sgn, FP64_POS_INF[62:0]};
      special_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      special_res = {sgn, 63'b0};
    end else begin
      is_special = 1'b0;
    end
  end

  always_comb begin
    rem_ge   = (rem >= {1'b0, mant_b});
    rem_sub  = rem - {1'b0, mant_b};
    rem_next = (rem_ge ? rem_sub : rem) << 1;
  end

  fp64_div_round_pack u_round_pack (
    .sign      (sign_q),
    .exp_q     (exp_q),
    .quot      (quot),
    .sticky_in (rem != '0),
    .res       (rp_result)
  );

  // Control FSM; all handshake outputs are registered so neither valid path is combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      rem         <= '0;
      mant_b      <= '0;
      quot        <= '0;
      cnt         <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          sign_q      <= sgn;
          div_by_zero <= 1'b0;
          if (is_special) begin
            result      <= special_res;
            div_by_zero <= special_dbz;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            // Pre-scaling the dividend keeps the quotient in [1,2), so bit 53 is always the leading one.
            mant_b <= mb;
            quot   <= '0;
            cnt    <= '0;
            rem    <= (ma < mb) ? {ma, 1'b0} : {1'b0, ma};
            exp_q  <= ea - eb + 13'(FP64_BIAS) - ((ma < mb) ? 13'sd1 : 13'sd0);
            state  <= ITER;
          end
        end
        ITER: begin
          quot <= {quot[52:0], rem_ge};
          rem  <= rem_next;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd53) state <= ROUND;
        end
        ROUND: begin
          result    <= rp_result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
